// File: rtl/control_unit_pkg.sv
// Shared control-path definitions: opcodes, ALU codes, sequencer states and the strobe bundle.
// Imported by the control unit, the datapath and the ALU.
package control_pkg;

  localparam int unsigned OPW  = 5;
  localparam int unsigned ALUW = 5;

  typedef logic [OPW-1:0]  opcode_t;
  typedef logic [ALUW-1:0] alu_sel_t;

  localparam opcode_t OP_LD   = 5'b00000;
  localparam opcode_t OP_LDI  = 5'b00001;
  localparam opcode_t OP_ST   = 5'b00010;
  localparam opcode_t OP_ADD  = 5'b00011;
  localparam opcode_t OP_SUB  = 5'b00100;
  localparam opcode_t OP_AND  = 5'b00101;
  localparam opcode_t OP_OR   = 5'b00110;
  localparam opcode_t OP_SHR  = 5'b00111;
  localparam opcode_t OP_SHL  = 5'b01000;
  localparam opcode_t OP_ADDI = 5'b01100;
  localparam opcode_t OP_ANDI = 5'b01101;
  localparam opcode_t OP_ORI  = 5'b01110;
  localparam opcode_t OP_BR   = 5'b10011;
  localparam opcode_t OP_JR   = 5'b10100;
  localparam opcode_t OP_NOP  = 5'b11010;
  localparam opcode_t OP_HALT = 5'b11011;

  localparam alu_sel_t ALU_ADD = 5'b00011;
  localparam alu_sel_t ALU_SUB = 5'b00100;
  localparam alu_sel_t ALU_AND = 5'b00101;
  localparam alu_sel_t ALU_OR  = 5'b00110;
  localparam alu_sel_t ALU_SHR = 5'b00111;
  localparam alu_sel_t ALU_SHL = 5'b01000;

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, PAUSE, HALT
  } state_e;

  typedef struct packed {
    logic     PCout, ZLOWout, MDRout, BAout, Cout, R_out;
    logic     PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, R_in, CON_in;
    logic     Inc_PC, Gra, Grb, Grc, read, write;
    alu_sel_t ALU_select;
    logic     run;
  } strobes_t;

  function automatic logic is_rtype(input opcode_t op);
    return (op >= OP_ADD) && (op <= OP_SHL);
  endfunction

  function automatic logic is_imm(input opcode_t op);
    return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic is_mem(input opcode_t op);
    return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
  endfunction

  function automatic alu_sel_t imm_alu(input opcode_t op);
    case (op)
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle: instruction/status inputs and all control strobes.
interface control_unit_if;
  import control_pkg::*;

  logic [31:0] IR;
  logic        con_ff, mem_done, stop;
  logic        PCout, ZLOWout, MDRout, BAout, Cout, R_out;
  logic        PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, R_in, CON_in;
  logic        Inc_PC, Gra, Grb, Grc, read, write;
  alu_sel_t    ALU_select;
  logic        run;

  modport master (
    input  IR, con_ff, mem_done, stop,
    output PCout, ZLOWout, MDRout, BAout, Cout, R_out,
           PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, R_in, CON_in,
           Inc_PC, Gra, Grb, Grc, read, write, ALU_select, run
  );

  modport slave (
    output IR, con_ff, mem_done, stop,
    input  PCout, ZLOWout, MDRout, BAout, Cout, R_out,
           PC_in, IR_in, Y_in, Z_in, MAR_in, MDR_in, R_in, CON_in,
           Inc_PC, Gra, Grb, Grc, read, write, ALU_select, run
  );
endinterface

// File: rtl/control_unit_decode.sv
// Moore strobe decode: (state, opcode, con_ff) -> control strobe bundle. Purely combinational.
module control_decode
  import control_pkg::*;
(
  input  state_e   state,
  input  opcode_t  opcode,
  input  logic     con_ff,
  output strobes_t s
);

  always_comb begin
    s     = '0;
    s.run = (state != RST) && (state != PAUSE) && (state != HALT);
    case (state)
      T0: begin s.PCout = 1'b1; s.MAR_in = 1'b1; s.Inc_PC = 1'b1; s.Z_in = 1'b1; end
      T1: begin s.ZLOWout = 1'b1; s.PC_in = 1'b1; s.read = 1'b1; s.MDR_in = 1'b1; end
      T2: begin s.MDRout = 1'b1; s.IR_in = 1'b1; end
      T3: begin
        if (is_rtype(opcode) || is_imm(opcode)) begin
          s.Grb = 1'b1; s.R_out = 1'b1; s.Y_in = 1'b1;
        end else if (is_mem(opcode)) begin
          s.Grb = 1'b1; s.BAout = 1'b1; s.Y_in = 1'b1;
        end else if (opcode == OP_BR) begin
          s.Gra = 1'b1; s.R_out = 1'b1; s.CON_in = 1'b1;
        end else if (opcode == OP_JR) begin
          s.Gra = 1'b1; s.R_out = 1'b1; s.PC_in = 1'b1;
        end
      end
      T4: begin
        if (is_rtype(opcode)) begin
          s.Grc = 1'b1; s.R_out = 1'b1; s.Z_in = 1'b1; s.ALU_select = opcode;
        end else if (is_imm(opcode)) begin
          s.Cout = 1'b1; s.Z_in = 1'b1; s.ALU_select = imm_alu(opcode);
        end else if (is_mem(opcode)) begin
          s.Cout = 1'b1; s.Z_in = 1'b1; s.ALU_select = ALU_ADD;
        end else if (opcode == OP_BR) begin
          s.PCout = 1'b1; s.Y_in = 1'b1;
        end
      end
      T5: begin
        if (opcode == OP_LD || opcode == OP_ST) begin
          s.ZLOWout = 1'b1; s.MAR_in = 1'b1;
        end else if (opcode == OP_BR) begin
          s.Cout = 1'b1; s.Z_in = 1'b1; s.ALU_select = ALU_ADD;
        end else if (is_rtype(opcode) || is_imm(opcode) || opcode == OP_LDI) begin
          s.ZLOWout = 1'b1; s.Gra = 1'b1; s.R_in = 1'b1;
        end
      end
      T6: begin
        if (opcode == OP_LD) begin
          s.read = 1'b1; s.MDR_in = 1'b1;
        end else if (opcode == OP_ST) begin
          s.Gra = 1'b1; s.R_out = 1'b1; s.MDR_in = 1'b1;
        end else if (opcode == OP_BR && con_ff) begin
          s.ZLOWout = 1'b1; s.PC_in = 1'b1;
        end
      end
      T7: begin
        if (opcode == OP_LD) begin
          s.MDRout = 1'b1; s.Gra = 1'b1; s.R_in = 1'b1;
        end else if (opcode == OP_ST) begin
          s.write = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer: state register and next-state logic; strobes come from control_decode.
module control_unit
  import control_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  control_unit_if.master bus
);

  state_e   state_q, state_d;
  opcode_t  opcode;
  strobes_t str;
  logic     fin;
  logic     unused_ir;

  assign opcode    = bus.IR[31 -: OPW];
  assign unused_ir = ^bus.IR[31-OPW:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RST;
    else        state_q <= state_d;
  end

  // fin marks the last execute cycle; the only point where stop is honoured.
  always_comb begin
    state_d = state_q;
    fin     = 1'b0;
    case (state_q)
      RST:   state_d = T0;
      T0:    state_d = T1;
      T1:    if (bus.mem_done) state_d = T2;
      T2:    state_d = T3;
      T3: begin
        if (opcode == OP_HALT) state_d = HALT;
        else if (is_rtype(opcode) || is_imm(opcode) || is_mem(opcode) || opcode == OP_BR)
          state_d = T4;
        else fin = 1'b1;
      end
      T4:    state_d = T5;
      T5: begin
        if (opcode == OP_LD || opcode == OP_ST || opcode == OP_BR) state_d = T6;
        else fin = 1'b1;
      end
      T6: begin
        if (opcode == OP_LD) begin
          if (bus.mem_done) state_d = T7;
        end else if (opcode == OP_ST) state_d = T7;
        else fin = 1'b1;
      end
      T7:    if (!(opcode == OP_ST && !bus.mem_done)) fin = 1'b1;
      PAUSE: if (!bus.stop) state_d = T0;
      HALT:  state_d = HALT;
      default: state_d = RST;
    endcase
    if (fin) state_d = bus.stop ? PAUSE : T0;
  end

  control_decode u_decode (
    .state  (state_q),
    .opcode (opcode),
    .con_ff (bus.con_ff),
    .s      (str)
  );

  assign bus.PCout      = str.PCout;
  assign bus.ZLOWout    = str.ZLOWout;
  assign bus.MDRout     = str.MDRout;
  assign bus.BAout      = str.BAout;
  assign bus.Cout       = str.Cout;
  assign bus.R_out      = str.R_out;
  assign bus.PC_in      = str.PC_in;
  assign bus.IR_in      = str.IR_in;
  assign bus.Y_in       = str.Y_in;
  assign bus.Z_in       = str.Z_in;
  assign bus.MAR_in     = str.MAR_in;
  assign bus.MDR_in     = str.MDR_in;
  assign bus.R_in       = str.R_in;
  assign bus.CON_in     = str.CON_in;
  assign bus.Inc_PC     = str.Inc_PC;
  assign bus.Gra        = str.Gra;
  assign bus.Grb        = str.Grb;
  assign bus.Grc        = str.Grc;
  assign bus.read       = str.read;
  assign bus.write      = str.write;
  assign bus.ALU_select = str.ALU_select;
  assign bus.run        = str.run;

endmodule
